// File: rtl/key_receiver.sv
// key_receiver: 8N1 UART receiver feeding a terminal key-command decoder (w/s, space, ESC [ A/B).
// Latency: byte_valid 1 cycle after the stop-bit sample; command pulses 1 cycle after byte_valid.
// Backpressure: none; the serial line cannot be stalled, every pulse is fire-and-forget.
// Optional ESC_TIMEOUT_EN: abandon a partial escape sequence after ESC_TIMEOUT_CYCLES idle cycles.
module key_receiver #(
    parameter int CLKS_PER_BIT       = 868,
    parameter int ESC_TIMEOUT_CYCLES = 1000000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       rx,
    output logic       byte_valid,
    output logic [7:0] byte_data,
    output logic       framing_error,
    output logic       paddle_0_up,
    output logic       paddle_0_down,
    output logic       paddle_1_up,
    output logic       paddle_1_down,
    output logic       start_pulse
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_t;
    typedef enum logic [1:0] {D_NORM, D_ESC, D_CSI} dec_state_t;

    // ------------------------------------------------------------------
    // Input synchroniser
    // ------------------------------------------------------------------
    logic rx_meta;
    logic rx_s;

    // Two-flop synchroniser; resets to the idle (high) line level
    always_ff @(posedge clock) begin
        if (reset) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
        end
    end

    // ------------------------------------------------------------------
    // Receive FSM
    // ------------------------------------------------------------------
    rx_state_t        rx_state, rx_state_nxt;
    logic [CNT_W-1:0] clk_cnt, clk_cnt_nxt;
    logic [2:0]       bit_idx, bit_idx_nxt;
    logic [7:0]       shift_reg, shift_nxt;
    logic [7:0]       byte_data_nxt;
    logic             byte_vld_nxt;
    logic             frm_err_nxt;

    // Receive state, bit timing and received-byte registers
    always_ff @(posedge clock) begin
        if (reset) begin
            rx_state      <= R_IDLE;
            clk_cnt       <= '0;
            bit_idx       <= '0;
            shift_reg     <= '0;
            byte_data     <= 8'h00;
            byte_valid    <= 1'b0;
            framing_error <= 1'b0;
        end else begin
            rx_state      <= rx_state_nxt;
            clk_cnt       <= clk_cnt_nxt;
            bit_idx       <= bit_idx_nxt;
            shift_reg     <= shift_nxt;
            byte_data     <= byte_data_nxt;
            byte_valid    <= byte_vld_nxt;
            framing_error <= frm_err_nxt;
        end
    end

    // Frame sequencing: mid-bit sampling keyed off the half-bit start check
    always_comb begin
        rx_state_nxt  = rx_state;
        clk_cnt_nxt   = clk_cnt + 1'b1;
        bit_idx_nxt   = bit_idx;
        shift_nxt     = shift_reg;
        byte_data_nxt = byte_data;
        byte_vld_nxt  = 1'b0;
        frm_err_nxt   = 1'b0;
        case (rx_state)
            R_IDLE: begin
                clk_cnt_nxt = '0;
                if (!rx_s) begin
                    rx_state_nxt = R_START;
                end
            end
            R_START: begin
                if (clk_cnt == CNT_HALF) begin
                    clk_cnt_nxt = '0;
                    bit_idx_nxt = '0;
                    // A start bit that has gone high again by mid-bit was a glitch
                    rx_state_nxt = rx_s ? R_IDLE : R_DATA;
                end
            end
            R_DATA: begin
                if (clk_cnt == CNT_LAST) begin
                    clk_cnt_nxt = '0;
                    shift_nxt   = {rx_s, shift_reg[7:1]};
                    bit_idx_nxt = bit_idx + 1'b1;
                    if (bit_idx == 3'd7) begin
                        rx_state_nxt = R_STOP;
                    end
                end
            end
            R_STOP: begin
                if (clk_cnt == CNT_LAST) begin
                    clk_cnt_nxt  = '0;
                    rx_state_nxt = R_IDLE;
                    if (rx_s) begin
                        byte_vld_nxt  = 1'b1;
                        byte_data_nxt = shift_reg;
                    end else begin
                        frm_err_nxt = 1'b1;
                    end
                end
            end
            default: begin
                rx_state_nxt = R_IDLE;
                clk_cnt_nxt  = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Key-command decoder
    // ------------------------------------------------------------------
    dec_state_t dec_state, dec_state_nxt;
    logic       norm_decode;
    logic       p0_up_nxt, p0_dn_nxt, p1_up_nxt, p1_dn_nxt, start_nxt;
    logic       esc_timeout_hit;

`ifdef ESC_TIMEOUT_EN
    localparam int ESC_W = $clog2(ESC_TIMEOUT_CYCLES + 1);
    localparam logic [ESC_W-1:0] ESC_LIMIT = ESC_W'(ESC_TIMEOUT_CYCLES);
    logic [ESC_W-1:0] esc_idle_cnt;

    assign esc_timeout_hit = (esc_idle_cnt == ESC_LIMIT);

    // Idle-cycle count while an escape sequence is partially received
    always_ff @(posedge clock) begin
        if (reset || dec_state == D_NORM || byte_valid || esc_timeout_hit) begin
            esc_idle_cnt <= '0;
        end else begin
            esc_idle_cnt <= esc_idle_cnt + 1'b1;
        end
    end
`else
    // Without the timeout a partial sequence waits forever for its next byte
    assign esc_timeout_hit = (ESC_TIMEOUT_CYCLES < 0);
`endif

    // Decoder state and registered single-cycle command pulses
    always_ff @(posedge clock) begin
        if (reset) begin
            dec_state     <= D_NORM;
            paddle_0_up   <= 1'b0;
            paddle_0_down <= 1'b0;
            paddle_1_up   <= 1'b0;
            paddle_1_down <= 1'b0;
            start_pulse   <= 1'b0;
        end else begin
            dec_state     <= dec_state_nxt;
            paddle_0_up   <= p0_up_nxt;
            paddle_0_down <= p0_dn_nxt;
            paddle_1_up   <= p1_up_nxt;
            paddle_1_down <= p1_dn_nxt;
            start_pulse   <= start_nxt;
        end
    end

    // Sequence parsing; a non-'[' byte after ESC falls back to plain-key decoding
    always_comb begin
        dec_state_nxt = dec_state;
        norm_decode   = 1'b0;
        p0_up_nxt     = 1'b0;
        p0_dn_nxt     = 1'b0;
        p1_up_nxt     = 1'b0;
        p1_dn_nxt     = 1'b0;
        start_nxt     = 1'b0;
        if (byte_valid) begin
            case (dec_state)
                D_NORM: norm_decode = 1'b1;
                D_ESC: begin
                    if (byte_data == 8'h5B) begin
                        dec_state_nxt = D_CSI;
                    end else if (byte_data != 8'h1B) begin
                        dec_state_nxt = D_NORM;
                        norm_decode   = 1'b1;
                    end
                end
                D_CSI: begin
                    p1_up_nxt     = (byte_data == 8'h41);
                    p1_dn_nxt     = (byte_data == 8'h42);
                    dec_state_nxt = D_NORM;
                end
                default: dec_state_nxt = D_NORM;
            endcase
            if (norm_decode) begin
                case (byte_data)
                    8'h77, 8'h57: p0_up_nxt = 1'b1;
                    8'h73, 8'h53: p0_dn_nxt = 1'b1;
                    8'h20:        start_nxt = 1'b1;
                    8'h1B:        dec_state_nxt = D_ESC;
                    default:      ;
                endcase
            end
        end else if (esc_timeout_hit) begin
            dec_state_nxt = D_NORM;
        end
    end

endmodule

// File: tb/tb_key_receiver.sv
// tb_key_receiver: drives serial frames into key_receiver and scores bytes and command pulses.
// Latency: expectations settle a fixed idle window after each frame.
// Backpressure: none; the bench paces the line itself.
module tb_key_receiver;

    localparam int CPB = 16;
    localparam int TMO = 200;

    logic       clock = 1'b0;
    logic       reset;
    logic       rx;
    logic       byte_valid;
    logic [7:0] byte_data;
    logic       framing_error;
    logic       paddle_0_up, paddle_0_down, paddle_1_up, paddle_1_down, start_pulse;

    key_receiver #(.CLKS_PER_BIT(CPB), .ESC_TIMEOUT_CYCLES(TMO)) dut (
        .clock(clock), .reset(reset), .rx(rx),
        .byte_valid(byte_valid), .byte_data(byte_data), .framing_error(framing_error),
        .paddle_0_up(paddle_0_up), .paddle_0_down(paddle_0_down),
        .paddle_1_up(paddle_1_up), .paddle_1_down(paddle_1_down),
        .start_pulse(start_pulse)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int last_bv = -10;
    int fe_cnt = 0, bad_lat = 0, multi_cnt = 0;
    int got_bytes[$], exp_bytes[$], got_cmds[$], exp_cmds[$];
    logic [7:0] esc_buf[$];
    int prev_send = -100000;
    logic [7:0] last_good = 8'h00;
    logic [7:0] pool[10] = '{8'h77, 8'h57, 8'h73, 8'h53, 8'h20, 8'h1B, 8'h5B, 8'h41, 8'h42, 8'h43};

    // Observation: record bytes, framing errors and command pulses (1=p0 up 2=p0 down 3=p1 up 4=p1 down 5=start)
    always @(negedge clock) begin : mon
        int n;
        cyc++;
        if (byte_valid === 1'b1) begin
            got_bytes.push_back(int'(byte_data));
            last_bv = cyc;
        end
        if (framing_error === 1'b1) fe_cnt++;
        n = 0;
        if (paddle_0_up === 1'b1)   begin got_cmds.push_back(1); n++; end
        if (paddle_0_down === 1'b1) begin got_cmds.push_back(2); n++; end
        if (paddle_1_up === 1'b1)   begin got_cmds.push_back(3); n++; end
        if (paddle_1_down === 1'b1) begin got_cmds.push_back(4); n++; end
        if (start_pulse === 1'b1)   begin got_cmds.push_back(5); n++; end
        if (n > 1) multi_cnt++;
        if (n > 0 && cyc != last_bv + 1) bad_lat++;
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    function automatic bit q_eq(input int a[$], input int b[$]);
        if (a.size() != b.size()) return 1'b0;
        foreach (a[i]) if (a[i] != b[i]) return 1'b0;
        return 1'b1;
    endfunction

    function automatic string q2s(input int q[$]);
        string s = "{";
        foreach (q[i]) s = {s, $sformatf(" %0h", q[i])};
        return {s, " }"};
    endfunction

    // Reference: a terminal key parser over the stream of correctly framed bytes
    function automatic void model_byte(input logic [7:0] b, input int gap);
`ifdef ESC_TIMEOUT_EN
        if (esc_buf.size() != 0 && gap > TMO + 1) esc_buf.delete();
`else
        if (gap < 0) esc_buf.delete();
`endif
        if (esc_buf.size() == 2) begin
            if (b == 8'h41) exp_cmds.push_back(3);
            else if (b == 8'h42) exp_cmds.push_back(4);
            esc_buf.delete();
        end else if (esc_buf.size() == 1 && b == 8'h5B) begin
            esc_buf.push_back(b);
        end else if (b == 8'h1B) begin
            esc_buf.delete();
            esc_buf.push_back(b);
        end else begin
            esc_buf.delete();
            if (b == 8'h77 || b == 8'h57) exp_cmds.push_back(1);
            else if (b == 8'h73 || b == 8'h53) exp_cmds.push_back(2);
            else if (b == 8'h20) exp_cmds.push_back(5);
        end
    endfunction

    task automatic clear_obs();
        got_bytes.delete(); exp_bytes.delete(); got_cmds.delete(); exp_cmds.delete();
        fe_cnt = 0; bad_lat = 0; multi_cnt = 0;
    endtask

    task automatic drive_bit(input logic v, input int n);
        repeat (n) begin
            @(negedge clock);
            rx = v;
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input bit good_stop);
        if (good_stop) begin
            model_byte(b, cyc - prev_send);
            prev_send = cyc;
            exp_bytes.push_back(int'(b));
            last_good = b;
        end
        drive_bit(1'b0, CPB);
        for (int i = 0; i < 8; i++) drive_bit(b[i], CPB);
        if (good_stop) begin
            drive_bit(1'b1, CPB);
        end else begin
            drive_bit(1'b0, CPB * 3 / 4);
            drive_bit(1'b1, CPB - CPB * 3 / 4);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        rx = 1'b1;
        repeat (4) @(negedge clock);
        checks++;
        if ({byte_valid, framing_error, paddle_0_up, paddle_0_down, paddle_1_up, paddle_1_down, start_pulse} !== 7'b0)
            begin errors++; $display("FAIL reset_pulses: got %b required 0000000", {byte_valid, framing_error, paddle_0_up, paddle_0_down, paddle_1_up, paddle_1_down, start_pulse}); end
        checks++;
        if (byte_data !== 8'h00) begin errors++; $display("FAIL reset_byte_data: got %h required 00", byte_data); end
        reset = 1'b0;
        esc_buf.delete();
        clear_obs();
        drive_bit(1'b1, 3 * CPB);
        checks++;
        if (got_bytes.size() != 0 || got_cmds.size() != 0 || fe_cnt != 0)
            begin errors++; $display("FAIL reset_quiet: got %0d bytes %0d cmds %0d ferr required none", got_bytes.size(), got_cmds.size(), fe_cnt); end
    endtask

    task automatic test_single();
        clear_obs();
        send_byte(8'h77, 1'b1);
        drive_bit(1'b1, 20);
        checks++;
        if (!q_eq(got_bytes, exp_bytes)) begin errors++; $display("FAIL single_bytes: got %s required %s", q2s(got_bytes), q2s(exp_bytes)); end
        checks++;
        if (!q_eq(got_cmds, exp_cmds)) begin errors++; $display("FAIL single_cmds: got %s required %s", q2s(got_cmds), q2s(exp_cmds)); end
        checks++;
        if (bad_lat != 0 || multi_cnt != 0 || fe_cnt != 0) begin errors++; $display("FAIL single_timing: late %0d multi %0d ferr %0d required 0", bad_lat, multi_cnt, fe_cnt); end
        checks++;
        if (byte_data !== 8'h77) begin errors++; $display("FAIL single_hold: got %h required 77", byte_data); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] seq[6] = '{8'h1B, 8'h5B, 8'h41, 8'h1B, 8'h5B, 8'h42};
        clear_obs();
        foreach (seq[i]) send_byte(seq[i], 1'b1);
        drive_bit(1'b1, 20);
        checks++;
        if (!q_eq(got_bytes, exp_bytes)) begin errors++; $display("FAIL b2b_bytes: got %s required %s", q2s(got_bytes), q2s(exp_bytes)); end
        checks++;
        if (!q_eq(got_cmds, exp_cmds)) begin errors++; $display("FAIL b2b_cmds: got %s required %s", q2s(got_cmds), q2s(exp_cmds)); end
        checks++;
        if (bad_lat != 0 || multi_cnt != 0) begin errors++; $display("FAIL b2b_timing: late %0d multi %0d required 0", bad_lat, multi_cnt); end
    endtask

    task automatic test_esc_redecode();
        logic [7:0] seq[7] = '{8'h1B, 8'h73, 8'h1B, 8'h5B, 8'h43, 8'h41, 8'h77};
        clear_obs();
        foreach (seq[i]) begin
            send_byte(seq[i], 1'b1);
            drive_bit(1'b1, $urandom_range(0, 10));
        end
        drive_bit(1'b1, 20);
        checks++;
        if (!q_eq(got_cmds, exp_cmds)) begin errors++; $display("FAIL esc_cmds: got %s required %s", q2s(got_cmds), q2s(exp_cmds)); end
        checks++;
        if (bad_lat != 0 || multi_cnt != 0) begin errors++; $display("FAIL esc_timing: late %0d multi %0d required 0", bad_lat, multi_cnt); end
    endtask

    task automatic test_framing();
        logic [7:0] prev;
        prev = last_good;
        clear_obs();
        send_byte(8'h20, 1'b0);
        drive_bit(1'b1, 3 * CPB);
        checks++;
        if (fe_cnt != 1) begin errors++; $display("FAIL frame_err_count: got %0d required 1", fe_cnt); end
        checks++;
        if (got_bytes.size() != 0 || got_cmds.size() != 0) begin errors++; $display("FAIL frame_discard: got bytes %s cmds %s required none", q2s(got_bytes), q2s(got_cmds)); end
        checks++;
        if (byte_data !== prev) begin errors++; $display("FAIL frame_hold: got %h required %h", byte_data, prev); end
        send_byte(8'h20, 1'b1);
        drive_bit(1'b1, 20);
        checks++;
        if (!q_eq(got_cmds, exp_cmds)) begin errors++; $display("FAIL frame_recover: got %s required %s", q2s(got_cmds), q2s(exp_cmds)); end
    endtask

    task automatic test_glitch();
        clear_obs();
        drive_bit(1'b0, 3);
        drive_bit(1'b1, 2 * CPB);
        checks++;
        if (got_bytes.size() != 0 || fe_cnt != 0 || got_cmds.size() != 0) begin errors++; $display("FAIL glitch_quiet: got %0d bytes %0d ferr required none", got_bytes.size(), fe_cnt); end
        send_byte(8'h53, 1'b1);
        drive_bit(1'b1, 20);
        checks++;
        if (!q_eq(got_cmds, exp_cmds)) begin errors++; $display("FAIL glitch_cmds: got %s required %s", q2s(got_cmds), q2s(exp_cmds)); end
    endtask

    task automatic test_reset_mid();
        logic [7:0] b;
        clear_obs();
        send_byte(8'h1B, 1'b1);
        send_byte(8'h5B, 1'b1);
        b = 8'hA7;
        drive_bit(1'b0, CPB);
        for (int i = 0; i < 4; i++) drive_bit(b[i], CPB);
        drive_bit(b[4], CPB / 2);
        reset = 1'b1;
        rx = 1'b1;
        repeat (3) @(negedge clock);
        checks++;
        if ({byte_valid, framing_error, paddle_0_up, paddle_0_down, paddle_1_up, paddle_1_down, start_pulse, byte_data} !== 15'b0)
            begin errors++; $display("FAIL midreset_outputs: got %b required all zero", {byte_valid, framing_error, paddle_0_up, paddle_0_down, paddle_1_up, paddle_1_down, start_pulse, byte_data}); end
        reset = 1'b0;
        esc_buf.delete();
        last_good = 8'h00;
        drive_bit(1'b1, 3 * CPB);
        checks++;
        if (got_bytes.size() != 2 || got_cmds.size() != 0 || fe_cnt != 0) begin errors++; $display("FAIL midreset_drop: got bytes %s cmds %s ferr %0d required 2 bytes only", q2s(got_bytes), q2s(got_cmds), fe_cnt); end
        send_byte(8'h41, 1'b1);
        send_byte(8'h57, 1'b1);
        drive_bit(1'b1, 20);
        checks++;
        if (!q_eq(got_cmds, exp_cmds)) begin errors++; $display("FAIL midreset_cmds: got %s required %s", q2s(got_cmds), q2s(exp_cmds)); end
    endtask

    task automatic test_random();
        logic [7:0] b;
        clear_obs();
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 9) == 0) b = 8'($urandom_range(0, 255));
            else b = pool[$urandom_range(0, 9)];
            send_byte(b, 1'b1);
            drive_bit(1'b1, $urandom_range(0, 20));
        end
        drive_bit(1'b1, 20);
        checks++;
        if (!q_eq(got_bytes, exp_bytes)) begin errors++; $display("FAIL random_bytes: got %s required %s", q2s(got_bytes), q2s(exp_bytes)); end
        checks++;
        if (!q_eq(got_cmds, exp_cmds)) begin errors++; $display("FAIL random_cmds: got %s required %s", q2s(got_cmds), q2s(exp_cmds)); end
        checks++;
        if (bad_lat != 0 || multi_cnt != 0 || fe_cnt != 0) begin errors++; $display("FAIL random_timing: late %0d multi %0d ferr %0d required 0", bad_lat, multi_cnt, fe_cnt); end
    endtask

    task automatic test_esc_timeout();
        int req_p1_up;
        clear_obs();
        send_byte(8'h1B, 1'b1);
        drive_bit(1'b1, 250);
        send_byte(8'h5B, 1'b1);
        send_byte(8'h41, 1'b1);
        drive_bit(1'b1, 20);
`ifdef ESC_TIMEOUT_EN
        req_p1_up = 0;
`else
        req_p1_up = 1;
`endif
        checks++;
        if (!q_eq(got_cmds, exp_cmds)) begin errors++; $display("FAIL timeout_cmds: got %s required %s", q2s(got_cmds), q2s(exp_cmds)); end
        checks++;
        if (got_cmds.size() != req_p1_up) begin errors++; $display("FAIL timeout_p1_up: got %0d pulses required %0d", got_cmds.size(), req_p1_up); end
    endtask

    initial begin
        reset = 1'b1;
        rx = 1'b1;
        test_reset();
        test_single();
        test_back_to_back();
        test_esc_redecode();
        test_framing();
        test_glitch();
        test_reset_mid();
        test_random();
        test_esc_timeout();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
